// File: rtl/ShellTypes.sv
// Shell-level interface types shared by all user blocks: soft-register request/response and AXI-stream beat.
// The stream struct carries the forward signals only; tready travels as a separate scalar against the flow.
package ShellTypes;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

    typedef struct packed {
        logic         tvalid;
        logic [511:0] tdata;
        logic         tlast;
        logic [4:0]   tid;
        logic [4:0]   tdest;
    } axi_stream_t;

endpackage

// File: rtl/axis_echo_pkg.sv
// Register map, buffered-beat layout and the per-lane adder used by the echo block.
// Shared by the top, the FIFO and anything that needs to decode the register space.
package axis_echo_pkg;

    localparam int LANES  = 16;
    localparam int LANE_W = 32;
    localparam int DATA_W = LANES * LANE_W;
    localparam int ID_W   = 5;
    localparam int CNT_W  = 48;

    localparam logic [31:0] ADDR_CTRL  = 32'h00;
    localparam logic [31:0] ADDR_FLUSH = 32'h08;
    localparam logic [31:0] ADDR_FDEST = 32'h10;
    localparam logic [31:0] ADDR_ADD   = 32'h18;
    localparam logic [31:0] ADDR_BIN   = 32'h20;
    localparam logic [31:0] ADDR_BOUT  = 32'h28;
    localparam logic [31:0] ADDR_PKTS  = 32'h30;
    localparam logic [31:0] ADDR_STALL = 32'h38;
    localparam logic [31:0] ADDR_OCC   = 32'h40;

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic              tlast;
        logic [ID_W-1:0]   tid;
    } fifo_entry_t;

    // Each 32-bit lane wraps on its own; carries never cross lane boundaries.
    function automatic logic [DATA_W-1:0] lane_add(input logic [DATA_W-1:0] d,
                                                   input logic [LANE_W-1:0] k);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W] + k;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_echo_fifo.sv
// In-order sync FIFO of stream beats; head is combinational from the array, so a push is visible next cycle.
// Flush wins over push/pop in the same cycle; push when full / pop when empty are ignored.
module axis_echo_fifo
    import axis_echo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  fifo_entry_t              i_push_dat,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fifo_entry_t              o_head_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t       r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~i_flush & ~o_full;
    assign w_pop   = i_pop  & ~i_flush & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage carries no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/axis_echo.sv
// Stream echo: buffers rx beats, re-emits them with a per-lane constant added and a rewritten tdest; min latency 1 cycle.
// rx tready = enable & !full, tx tvalid = enable & !empty; soft-register reads answer one cycle after the request.
module axis_echo
    import ShellTypes::*;
    import axis_echo_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  SoftRegReq   softreg_req,
    output SoftRegResp  softreg_resp,
    input  axi_stream_t axis_rx,
    output logic        axis_rx_tready,
    output axi_stream_t axis_tx,
    input  logic        axis_tx_tready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              r_enable;
    logic              r_route_mode;
    logic [ID_W-1:0]   r_fixed_dest;
    logic [LANE_W-1:0] r_add_const;
    logic [CNT_W-1:0]  r_beats_in;
    logic [CNT_W-1:0]  r_beats_out;
    logic [CNT_W-1:0]  r_pkts_out;
    logic [CNT_W-1:0]  r_stall_cyc;
    SoftRegResp        r_resp;

    logic              w_wr;
    logic              w_rd;
    logic              w_flush;
    logic              w_rx_rdy;
    logic              w_rx_fire;
    logic              w_tx_vld;
    logic              w_tx_fire;
    logic              w_stall;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    fifo_entry_t       w_push_dat;
    fifo_entry_t       w_head;
    logic [63:0]       w_rd_dat;
    logic              w_unused_ok;

    assign w_wr    = softreg_req.valid &  softreg_req.isWrite;
    assign w_rd    = softreg_req.valid & ~softreg_req.isWrite;
    assign w_flush = w_wr & (softreg_req.addr == ADDR_FLUSH);

    assign w_rx_rdy  = r_enable & ~w_full;
    assign w_rx_fire = axis_rx.tvalid & w_rx_rdy;
    assign w_tx_vld  = r_enable & ~w_empty;
    assign w_tx_fire = w_tx_vld & axis_tx_tready;
    assign w_stall   = w_tx_vld & ~axis_tx_tready;

    assign w_push_dat.tdata = axis_rx.tdata;
    assign w_push_dat.tlast = axis_rx.tlast;
    assign w_push_dat.tid   = axis_rx.tid;

    axis_echo_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_rx_fire),
        .i_push_dat (w_push_dat),
        .i_pop      (w_tx_fire),
        .i_flush    (w_flush),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable     <= 1'b0;
            r_route_mode <= 1'b0;
            r_fixed_dest <= '0;
            r_add_const  <= '0;
        end else if (w_wr) begin
            case (softreg_req.addr)
                ADDR_CTRL: begin
                    r_enable     <= softreg_req.data[0];
                    r_route_mode <= softreg_req.data[1];
                end
                ADDR_FDEST: r_fixed_dest <= softreg_req.data[ID_W-1:0];
                ADDR_ADD:   r_add_const  <= softreg_req.data[LANE_W-1:0];
                default: ;
            endcase
        end
    end

    // A flush discards whatever handshakes coincide with it, so nothing is counted that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beats_in  <= '0;
            r_beats_out <= '0;
            r_pkts_out  <= '0;
            r_stall_cyc <= '0;
        end else if (w_flush) begin
            r_beats_in  <= '0;
            r_beats_out <= '0;
            r_pkts_out  <= '0;
            r_stall_cyc <= '0;
        end else begin
            r_beats_in  <= r_beats_in  + CNT_W'(w_rx_fire);
            r_beats_out <= r_beats_out + CNT_W'(w_tx_fire);
            r_pkts_out  <= r_pkts_out  + CNT_W'(w_tx_fire & w_head.tlast);
            r_stall_cyc <= r_stall_cyc + CNT_W'(w_stall);
        end
    end

    always_comb begin
        w_rd_dat = '0;
        case (softreg_req.addr)
            ADDR_CTRL:  w_rd_dat = {62'b0, r_route_mode, r_enable};
            ADDR_FDEST: w_rd_dat = 64'(r_fixed_dest);
            ADDR_ADD:   w_rd_dat = 64'(r_add_const);
            ADDR_BIN:   w_rd_dat = 64'(r_beats_in);
            ADDR_BOUT:  w_rd_dat = 64'(r_beats_out);
            ADDR_PKTS:  w_rd_dat = 64'(r_pkts_out);
            ADDR_STALL: w_rd_dat = 64'(r_stall_cyc);
            ADDR_OCC:   w_rd_dat = 64'(w_count);
            default:    w_rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp <= '0;
        end else begin
            r_resp.valid <= w_rd;
            if (w_rd) r_resp.data <= w_rd_dat;
        end
    end

    assign softreg_resp   = r_resp;
    assign axis_rx_tready = w_rx_rdy;

    always_comb begin
        axis_tx        = '0;
        axis_tx.tvalid = w_tx_vld;
        axis_tx.tdata  = lane_add(w_head.tdata, r_add_const);
        axis_tx.tlast  = w_head.tlast;
        axis_tx.tid    = w_head.tid;
        axis_tx.tdest  = r_route_mode ? r_fixed_dest : w_head.tid;
    end

    assign w_unused_ok = ^{axis_rx.tdest, softreg_req.data[63:LANE_W]};

endmodule

// File: tb/tb_axis_echo.sv
module tb_axis_echo;
    import ShellTypes::*;
    import axis_echo_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    SoftRegReq   req;
    SoftRegResp  resp;
    axi_stream_t rx;
    axi_stream_t tx;
    logic        rx_rdy;
    logic        tx_rdy;

    always #5 clk = ~clk;

    axis_echo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .softreg_req    (req),
        .softreg_resp   (resp),
        .axis_rx        (rx),
        .axis_rx_tready (rx_rdy),
        .axis_tx        (tx),
        .axis_tx_tready (tx_rdy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: a queue of beats plus counters ----------------
    fifo_entry_t mq[$];
    logic        m_en, m_route;
    logic [4:0]  m_fdest;
    logic [31:0] m_add;
    longint      m_bin, m_bout, m_pkts, m_stall;
    int          tx_seen = 0;
    fifo_entry_t me, mnew;
    logic [511:0] m_exp;
    bit          m_rxf, m_txf, m_stl;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_en = 0; m_route = 0; m_fdest = 0; m_add = 0;
            m_bin = 0; m_bout = 0; m_pkts = 0; m_stall = 0;
        end else begin
            check("rx_tready", rx_rdy, m_en && mq.size() < DEPTH);
            check("tx_tvalid", tx.tvalid, m_en && mq.size() > 0);
            if (req.valid && req.isWrite && req.addr == ADDR_FLUSH) begin
                mq.delete();
                m_bin = 0; m_bout = 0; m_pkts = 0; m_stall = 0;
            end else begin
                m_rxf = m_en && mq.size() < DEPTH && rx.tvalid;
                m_txf = m_en && mq.size() > 0 && tx_rdy;
                m_stl = m_en && mq.size() > 0 && !tx_rdy;
                if (m_stl) m_stall++;
                if (m_txf) begin
                    me = mq.pop_front();
                    for (int i = 0; i < 16; i++) m_exp[32*i +: 32] = me.tdata[32*i +: 32] + m_add;
                    check("tx_tdata", tx.tdata, m_exp);
                    check("tx_tlast", tx.tlast, me.tlast);
                    check("tx_tdest", tx.tdest, m_route ? m_fdest : me.tid);
                    m_bout++;
                    if (me.tlast) m_pkts++;
                    tx_seen++;
                end
                if (m_rxf) begin
                    mnew.tdata = rx.tdata; mnew.tlast = rx.tlast; mnew.tid = rx.tid;
                    mq.push_back(mnew);
                    m_bin++;
                end
            end
            if (req.valid && req.isWrite) begin
                case (req.addr)
                    ADDR_CTRL:  begin m_en = req.data[0]; m_route = req.data[1]; end
                    ADDR_FDEST: m_fdest = req.data[4:0];
                    ADDR_ADD:   m_add = req.data[31:0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers (all called at posedge+1) ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [63:0] d);
        req.valid = 1; req.isWrite = 1; req.addr = a; req.data = d;
        tick();
        req.valid = 0; req.isWrite = 0;
    endtask

    task automatic reg_read(input logic [31:0] a, output logic [63:0] d);
        req.valid = 1; req.isWrite = 0; req.addr = a; req.data = '0;
        tick();
        check("resp_valid", resp.valid, 1'b1);
        d = resp.data;
        req.valid = 0;
    endtask

    task automatic reg_check(input string name, input logic [31:0] a, input logic [63:0] exp);
        logic [63:0] d;
        reg_read(a, d);
        check(name, d, exp);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic send_beat(input logic [511:0] d, input logic last, input logic [4:0] id, input int gap_max);
        logic acc;
        int   guard;
        guard = 0;
        rx.tvalid = 1; rx.tdata = d; rx.tlast = last; rx.tid = id; rx.tdest = '0;
        do begin
            @(negedge clk);
            acc = rx_rdy;
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 300);
        check("rx_accept", acc, 1'b1);
        rx.tvalid = 0;
        repeat ($urandom_range(0, gap_max)) tick();
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (mq.size() > 0 && g < 1000) begin tick(); g++; end
        check("drain", mq.size(), 0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
    } reg_vec_t;
    reg_vec_t tv[12];

    logic [63:0]  s1, s2;
    logic [511:0] d512;
    int           r_len;
    logic [4:0]   r_id;
    logic         r_mode;
    bit           rx_done = 0;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; req = '0; rx = '0; tx_rdy = 0;
        tick(3);
        check("rst_rx_tready", rx_rdy, 1'b0);
        check("rst_tx_tvalid", tx.tvalid, 1'b0);
        check("rst_resp_valid", resp.valid, 1'b0);
        check("rst_resp_data", resp.data, 64'h0);
        rst = 0;
        tick(2);
        check("post_rst_tready", rx_rdy, 1'b0);

        // register map: write (optional) then read back
        tv[0]  = '{1'b0, 32'h00,  64'h0, 64'h0};
        tv[1]  = '{1'b0, 32'h08,  64'h0, 64'h0};
        tv[2]  = '{1'b1, 32'h10,  64'hFFFF_FFFF_FFFF_FFE5, 64'h5};
        tv[3]  = '{1'b1, 32'h18,  64'hDEAD_BEEF_1234_5678, 64'h1234_5678};
        tv[4]  = '{1'b1, 32'h00,  64'hFFFF_FFFF_FFFF_FFF2, 64'h2};
        tv[5]  = '{1'b1, 32'h20,  64'd123, 64'h0};
        tv[6]  = '{1'b1, 32'h40,  64'd9, 64'h0};
        tv[7]  = '{1'b1, 32'h48,  64'hFF, 64'h0};
        tv[8]  = '{1'b0, 32'h100, 64'h0, 64'h0};
        tv[9]  = '{1'b1, 32'h00,  64'h0, 64'h0};
        tv[10] = '{1'b1, 32'h10,  64'h0, 64'h0};
        tv[11] = '{1'b1, 32'h18,  64'h0, 64'h0};
        for (int i = 0; i < 12; i++) begin
            if (tv[i].wr) reg_write(tv[i].addr, tv[i].wdata);
            reg_check($sformatf("reg_%0h_v%0d", tv[i].addr, i), tv[i].addr, tv[i].exp);
        end
        tick();
        check("resp_pulse", resp.valid, 1'b0);

        // plain echo of a 4-beat packet
        reg_write(ADDR_CTRL, 64'h1);
        tx_rdy = 1;
        for (int b = 0; b < 4; b++) send_beat(rnd512(), b == 3, 5'd3, 0);
        wait_drain();
        tick();
        check("t1_beats", tx_seen, 4);
        reg_check("t1_pkts", ADDR_PKTS, 64'd1);
        reg_check("t1_bout", ADDR_BOUT, 64'd4);

        // lane wrap with add_const = 1
        tx_rdy = 0;
        reg_write(ADDR_ADD, 64'h1);
        d512 = rnd512();
        d512[31:0] = 32'hFFFF_FFFF;
        d512[63:32] = 32'h5;
        send_beat(d512, 1'b1, 5'd1, 0);
        check("t2_lane0", tx.tdata[31:0], 32'h0);
        check("t2_lane1", tx.tdata[63:32], 32'h6);
        tx_rdy = 1;
        wait_drain();
        reg_write(ADDR_ADD, 64'h0);

        // fill to full with tx stalled, then release
        tx_rdy = 0;
        fork
            for (int b = 0; b < 20; b++) send_beat(rnd512(), b == 19, 5'd4, 0);
        join_none
        tick(25);
        check("t3_rx_blocked", rx_rdy, 1'b0);
        reg_check("t3_occ", ADDR_OCC, 64'd16);
        reg_check("t3_bin", ADDR_BIN, m_bin);
        reg_read(ADDR_STALL, s1);
        reg_read(ADDR_STALL, s2);
        check("t3_stall_step", s2 - s1, 64'd1);
        tx_rdy = 1;
        wait fork;
        wait_drain();
        tick();
        reg_check("t3_bout", ADDR_BOUT, 64'd25);
        reg_check("t3_pkts", ADDR_PKTS, 64'd3);
        reg_check("t3_bin_end", ADDR_BIN, 64'd25);

        // fixed routing
        reg_write(ADDR_CTRL, 64'h3);
        reg_write(ADDR_FDEST, 64'h7);
        tx_rdy = 0;
        send_beat(rnd512(), 1'b1, 5'd2, 0);
        check("t4_tdest", tx.tdest, 5'd7);
        tx_rdy = 1;
        wait_drain();
        reg_write(ADDR_CTRL, 64'h1);

        // enable cleared mid-packet retains contents
        tx_rdy = 0;
        for (int b = 0; b < 3; b++) send_beat(rnd512(), 1'b0, 5'd6, 0);
        reg_write(ADDR_CTRL, 64'h0);
        tx_rdy = 1;
        tick(2);
        check("t_en_rx", rx_rdy, 1'b0);
        check("t_en_tx", tx.tvalid, 1'b0);
        reg_check("t_en_occ", ADDR_OCC, 64'd3);
        reg_write(ADDR_CTRL, 64'h1);
        send_beat(rnd512(), 1'b1, 5'd6, 0);
        wait_drain();

        // flush with 5 buffered and a concurrent rx handshake
        tx_rdy = 0;
        for (int b = 0; b < 5; b++) send_beat(rnd512(), b == 4, 5'd9, 0);
        reg_check("t5_occ_pre", ADDR_OCC, 64'd5);
        rx.tvalid = 1; rx.tdata = rnd512(); rx.tlast = 0; rx.tid = 5'd9;
        req.valid = 1; req.isWrite = 1; req.addr = ADDR_FLUSH; req.data = 64'($urandom);
        @(negedge clk);
        check("t5_rx_hs", rx_rdy, 1'b1);
        @(posedge clk); #1;
        req.valid = 0; req.isWrite = 0; rx.tvalid = 0;
        check("t5_tvalid", tx.tvalid, 1'b0);
        reg_check("t5_occ", ADDR_OCC, 64'd0);
        reg_check("t5_bin", ADDR_BIN, 64'd0);
        reg_check("t5_bout", ADDR_BOUT, 64'd0);
        tx_rdy = 1;
        tick(3);
        check("t5_no_tx", tx.tvalid, 1'b0);

        // randomized traffic against the model
        r_mode = 1'($urandom);
        reg_write(ADDR_ADD, 64'($urandom));
        reg_write(ADDR_FDEST, 64'($urandom_range(0, 31)));
        reg_write(ADDR_CTRL, {62'b0, r_mode, 1'b1});
        rx_done = 0;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    r_len = $urandom_range(1, 4);
                    r_id = 5'($urandom);
                    for (int b = 0; b < r_len; b++) send_beat(rnd512(), b == r_len - 1, r_id, 2);
                end
                rx_done = 1;
            end
            begin
                while (!rx_done) begin tx_rdy = ($urandom_range(0, 3) != 0); tick(); end
            end
            begin
                tick(60);
                reg_write(ADDR_CTRL, {62'b0, r_mode, 1'b0});
                tick(8);
                reg_write(ADDR_CTRL, {62'b0, r_mode, 1'b1});
            end
        join
        tx_rdy = 1;
        wait_drain();
        tick();
        reg_check("rnd_bin", ADDR_BIN, m_bin);
        reg_check("rnd_bout", ADDR_BOUT, m_bout);
        reg_check("rnd_pkts", ADDR_PKTS, m_pkts);
        reg_check("rnd_stall", ADDR_STALL, m_stall);
        reg_check("rnd_occ", ADDR_OCC, 64'd0);

        // reset mid-packet
        reg_write(ADDR_CTRL, 64'h1);
        tx_rdy = 0;
        send_beat(rnd512(), 1'b0, 5'd5, 0);
        send_beat(rnd512(), 1'b0, 5'd5, 0);
        #2 rst = 1;
        #1;
        check("t6_rx_tready", rx_rdy, 1'b0);
        check("t6_tx_tvalid", tx.tvalid, 1'b0);
        tick(2);
        rst = 0;
        tick();
        for (int a = 0; a <= 8; a++) reg_check($sformatf("t6_reg_%0h", a * 8), 32'(a * 8), 64'h0);
        reg_write(ADDR_CTRL, 64'h1);
        tx_rdy = 1;
        tick(3);
        check("t6_no_partial", tx.tvalid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_echo.md
AXIS_ECHO -- requirements
Module: axis_echo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of beat entries buffered (power of two, >=2).
REQ-002 SHALL have port clk  input  1  user clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port softreg_req  input  SoftRegReq  soft register request (valid, isWrite, addr, 64-bit data).
REQ-005 SHALL have port softreg_resp  output  SoftRegResp  soft register read response (valid, 64-bit data).
REQ-006 SHALL have port axis_rx  axi_stream_t  --  inbound stream; block drives tready; samples tvalid, tdata[511:0], tlast, tid[4:0].
REQ-007 SHALL have port axis_tx  axi_stream_t  --  outbound stream; block drives tvalid, tdata[511:0], tlast, tdest[4:0]; samples tready.

Function
REQ-008 SHALL buffer each accepted rx beat {tdata, tlast, tid} in a FIFO_DEPTH-entry in-order FIFO.
REQ-009 SHALL drive axis_rx.tready = enable AND FIFO not full; no full-bypass, so a full FIFO blocks rx even if tx pops that cycle.
REQ-010 SHALL drive axis_tx.tvalid = enable AND FIFO not empty; no empty-bypass, so minimum rx-to-tx latency is 1 cycle.
REQ-011 SHALL drive axis_tx.tdata as the head entry data with add_const added to each of 16 32-bit lanes, modulo 2^32 per lane, no carry between lanes.
REQ-012 SHALL drive axis_tx.tlast from the head entry; tdest = head tid when route_mode=0, fixed_dest when route_mode=1.
REQ-013 SHALL hold tx tdata/tlast/tdest stable while tvalid=1 and tready=0, except across a flush or enable clear.
REQ-014 SHALL push and pop in the same cycle when both handshakes fire, occupancy unchanged.
REQ-015 SHALL on enable cleared mid-packet stop both handshakes and retain FIFO contents; re-enable resumes at the same head beat.
REQ-016 SHALL keep 48-bit wrapping counters: beats_in (rx handshakes), beats_out (tx handshakes), pkts_out (tx handshakes with tlast), stall_cyc (cycles tx tvalid=1 and tready=0).
REQ-017 SHALL return softreg read data exactly one cycle after a read request, with softreg_resp.valid pulsed for one cycle.
REQ-018 SHALL map registers: 0x00 ctrl (bit0 enable, bit1 route_mode), 0x08 flush (write-only, any data), 0x10 fixed_dest[4:0], 0x18 add_const[31:0], 0x20 beats_in, 0x28 beats_out, 0x30 pkts_out, 0x38 stall_cyc, 0x40 occupancy.
REQ-019 SHALL zero-extend narrow fields on read, return 0 for reads of 0x08 or unmapped addresses, and ignore writes to read-only or unmapped addresses.
REQ-020 SHALL on a write to 0x08 empty the FIFO and zero all four counters next cycle; a handshake in the same cycle is discarded and not counted.
REQ-021 SHALL let new ctrl/add_const/fixed_dest values affect tx outputs from the cycle after the write.

Reset
REQ-022 SHALL on rst asynchronously set: FIFO empty, counters 0, ctrl 0, fixed_dest 0, add_const 0, softreg_resp.valid 0, softreg_resp.data 0.
REQ-023 SHALL hold axis_rx.tready=0 and axis_tx.tvalid=0 during and after reset until enable is written 1.
REQ-024 SHALL discard in-flight data on reset mid-packet; no partial packet is emitted after release.

Structure
REQ-025 SHALL take SoftRegReq/SoftRegResp and axi_stream_t from ShellTypes; register address constants and the FIFO entry struct SHALL live in a shared package.
REQ-026 SHALL place buffering in one sub-module, axis_echo_fifo (sync FIFO: push, pop, flush, full, empty, count).

Verification
REQ-027 SHALL cover: enable=1, route_mode=0, add_const=0, send 4-beat packet tid=3 -> identical 4 beats out, tdest=3, tlast on beat 4, pkts_out=1.
REQ-028 SHALL cover: add_const=1, rx lane value 0xFFFFFFFF -> tx lane 0x00000000, adjacent lane unaffected.
REQ-029 SHALL cover: tx tready=0, send 20 beats -> rx tready drops after 16 accepted, occupancy=16, stall_cyc increments each cycle; release -> all 20 out in order.
REQ-030 SHALL cover: route_mode=1, fixed_dest=7, rx tid=2 -> tx tdest=7.
REQ-031 SHALL cover: flush written with 5 beats buffered and concurrent rx handshake -> occupancy=0, beats_in=0 next cycle, no tx beats.
REQ-032 SHALL cover: rst asserted mid-packet -> tready/tvalid 0 immediately, all readable registers 0 after release.
